// File: rtl/add_sub_top_fp32.sv
// Pipelined (1-cycle) IEEE-754 style adder/subtractor.
// Round to nearest, ties to even. Optional gradual underflow via FP_SUBNORMAL_EN;
// without it, subnormal inputs read as signed zero and subnormal results flush to zero.
module add_sub_top_fp32 #(
   parameter int EXP_BITS = 8,
   parameter int SIG_BITS = 23
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sign1,
   input  logic [EXP_BITS-1:0]        exp1,
   input  logic [SIG_BITS-1:0]        sig1,
   input  logic                       sign2,
   input  logic [EXP_BITS-1:0]        exp2,
   input  logic [SIG_BITS-1:0]        sig2,
   input  logic                       opcode,
   output logic [EXP_BITS+SIG_BITS:0] fp_out,
   output logic [2:0]                 err_o
);
   localparam int MW = SIG_BITS + 4;   // hidden + fraction + guard/round/sticky
   localparam int XW = EXP_BITS + 2;   // exponent with carry headroom and sign
   localparam logic [EXP_BITS-1:0] EXP_MAX   = '1;
   localparam logic [EXP_BITS-1:0] SHIFT_LIM = EXP_BITS'(SIG_BITS + 3);
   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_INVALID   = 3'd1;
   localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
   localparam logic [2:0] ERR_UNDERFLOW = 3'd3;
   localparam logic [EXP_BITS+SIG_BITS:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(SIG_BITS-1){1'b0}}};

   logic                       sign_b, nan_a, nan_b, inf_a, inf_b;
   logic [SIG_BITS:0]          man_a, man_b, big_m, sml_m;
   logic [EXP_BITS-1:0]        ex_a, ex_b, big_e, sml_e, diff;
   logic                       big_s, sml_s, lost, sum_zero, res_s;
   logic [MW-1:0]              sml_x, aligned, norm;
   logic [MW:0]                sum;
   logic [XW-1:0]              lz, exp_n, exp_r;
   logic [SIG_BITS+1:0]        man_r;
   logic [SIG_BITS-1:0]        frac;
   logic                       hidden, rnd_up, inexact;
   logic [EXP_BITS+SIG_BITS:0] res;
   logic [2:0]                 err_n;

   // Unpack operands; op2 sign flipped for SUB.
   always_comb begin
      sign_b = sign2 ^ opcode;
      nan_a  = (exp1 == EXP_MAX) && (sig1 != '0);
      nan_b  = (exp2 == EXP_MAX) && (sig2 != '0);
      inf_a  = (exp1 == EXP_MAX) && (sig1 == '0);
      inf_b  = (exp2 == EXP_MAX) && (sig2 == '0);
`ifdef FP_SUBNORMAL_EN
      man_a  = {exp1 != '0, sig1};
      man_b  = {exp2 != '0, sig2};
      ex_a   = (exp1 == '0) ? EXP_BITS'(1) : exp1;
      ex_b   = (exp2 == '0) ? EXP_BITS'(1) : exp2;
`else
      man_a  = (exp1 == '0) ? '0 : {1'b1, sig1};
      man_b  = (exp2 == '0) ? '0 : {1'b1, sig2};
      ex_a   = exp1;
      ex_b   = exp2;
`endif
   end

   // Order by magnitude, align the smaller operand, add or subtract.
   always_comb begin
      if ({ex_a, man_a} >= {ex_b, man_b}) begin
         big_s = sign1;  big_e = ex_a;  big_m = man_a;
         sml_s = sign_b; sml_e = ex_b;  sml_m = man_b;
      end else begin
         big_s = sign_b; big_e = ex_b;  big_m = man_b;
         sml_s = sign1;  sml_e = ex_a;  sml_m = man_a;
      end
      diff    = big_e - sml_e;
      sml_x   = {sml_m, 3'b000};
      aligned = '0;
      lost    = 1'b0;
      if (diff >= SHIFT_LIM) begin
         aligned[0] = |sml_m;
      end else begin
         aligned    = sml_x >> diff;
         lost       = (aligned << diff) != sml_x;
         aligned[0] = aligned[0] | lost;
      end
      if (big_s == sml_s)
         sum = {1'b0, big_m, 3'b000} + {1'b0, aligned};
      else
         sum = {1'b0, big_m, 3'b000} - {1'b0, aligned};
      sum_zero = (sum == '0);
      // Opposite-signed cancellation gives +0; only two negative zeros give -0.
      res_s    = sum_zero ? (big_s & sml_s) : big_s;
   end

   // Normalise (LZC left shift or 1-bit right on carry) and round to nearest even.
   always_comb begin
      lz = XW'(MW);
      for (int i = 0; i < MW; i++)
         if (sum[i]) lz = XW'(MW - 1 - i);
`ifdef FP_SUBNORMAL_EN
      // Stop at exponent 1 so tiny results stay denormalised.
      if (lz > ({2'b00, big_e} - XW'(1))) lz = {2'b00, big_e} - XW'(1);
`endif
      norm  = sum[MW-1:0] << lz;
      exp_n = {2'b00, big_e} - lz;
      if (sum[MW]) begin
         norm  = {sum[MW:2], sum[1] | sum[0]};
         exp_n = {2'b00, big_e} + XW'(1);
      end
      inexact = |norm[2:0];
      rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
      man_r   = {1'b0, norm[MW-1:3]} + {{(SIG_BITS+1){1'b0}}, rnd_up};
      if (man_r[SIG_BITS+1]) begin
         exp_r  = exp_n + XW'(1);
         frac   = man_r[SIG_BITS:1];
         hidden = 1'b1;
      end else begin
         exp_r  = exp_n;
         frac   = man_r[SIG_BITS-1:0];
         hidden = man_r[SIG_BITS];
      end
   end

   // Special-case selection; priority order gives INVALID > OVERFLOW > UNDERFLOW.
   always_comb begin
      res   = {res_s, exp_r[EXP_BITS-1:0], frac};
      err_n = ERR_NONE;
      if (nan_a || nan_b || (inf_a && inf_b && (sign1 != sign_b))) begin
         res   = QNAN;
         err_n = ERR_INVALID;
      end else if (inf_a || inf_b) begin
         res = {inf_a ? sign1 : sign_b, EXP_MAX, {SIG_BITS{1'b0}}};
      end else if (sum_zero) begin
         res = {res_s, {(EXP_BITS+SIG_BITS){1'b0}}};
      end else if (!exp_r[XW-1] && (exp_r >= {2'b00, EXP_MAX})) begin
         res   = {res_s, EXP_MAX, {SIG_BITS{1'b0}}};
         err_n = ERR_OVERFLOW;
`ifdef FP_SUBNORMAL_EN
      end else if (!hidden) begin
         res = {res_s, {EXP_BITS{1'b0}}, frac};
         if (inexact) err_n = ERR_UNDERFLOW;
`else
      end else if (exp_r[XW-1] || (exp_r == '0)) begin
         res   = {res_s, {(EXP_BITS+SIG_BITS){1'b0}}};
         err_n = ERR_UNDERFLOW;
`endif
      end
   end

   // Output register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         fp_out <= '0;
         err_o  <= ERR_NONE;
      end else begin
         fp_out <= res;
         err_o  <= err_n;
      end
   end
endmodule

// File: tb/tb_add_sub_top_fp32.sv
// Scoreboard bench for add_sub_top_fp32 (binary32 configuration).
module tb_add_sub_top_fp32;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sign1 = 1'b0, sign2 = 1'b0, opcode = 1'b0;
   logic [7:0]  exp1 = '0, exp2 = '0;
   logic [22:0] sig1 = '0, sig2 = '0;
   logic [31:0] fp_out;
   logic [2:0]  err_o;

   localparam logic [2:0] E_NONE = 3'd0, E_INV = 3'd1, E_OVF = 3'd2, E_UNF = 3'd3;

   add_sub_top_fp32 #(.EXP_BITS(8), .SIG_BITS(23)) dut (
      .clk(clk), .reset(reset),
      .sign1(sign1), .exp1(exp1), .sig1(sig1),
      .sign2(sign2), .exp2(exp2), .sig2(sig2),
      .opcode(opcode), .fp_out(fp_out), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [2:0]  e;
      logic        rst;
   } vec_t;

   typedef struct {
      logic [31:0] r;
      logic [2:0]  e;
      int          idx;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Apply one operation and record what must appear one cycle later.
   task automatic drive(input vec_t v, input int idx);
      exp_t x;
      reset  = v.rst;
      opcode = v.op;
      {sign1, exp1, sig1} = v.a;
      {sign2, exp2, sig2} = v.b;
      x.r = v.r; x.e = v.e; x.idx = idx;
      sb.push_back(x);
   endtask

   task automatic test_reset();
      exp_t e;
      @(negedge clk);
      drive('{1'b0, 32'h3F800000, 32'h40000000, 32'h00000000, E_NONE, 1'b1}, 0);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({fp_out, err_o} !== {e.r, e.e}) begin
         n_fail++;
         $display("FAIL reset: fp_out=%h err_o=%0d, expected fp_out=%h err_o=%0d", fp_out, err_o, e.r, e.e);
      end
   endtask

   task automatic test_arith();
      vec_t v[$];
      exp_t e;
      v.push_back('{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, E_NONE, 1'b0});
      v.push_back('{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, E_NONE, 1'b0});
      v.push_back('{1'b0, 32'h40400000, 32'hBF800000, 32'h40000000, E_NONE, 1'b0});
      v.push_back('{1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, E_NONE, 1'b0});
      v.push_back('{1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40400000, E_NONE, 1'b0});
      v.push_back('{1'b0, 32'h3F800000, 32'h00000000, 32'h3F800000, E_NONE, 1'b0});
      v.push_back('{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, E_NONE, 1'b0});
      v.push_back('{1'b0, 32'h00000000, 32'h80000000, 32'h00000000, E_NONE, 1'b0});
      v.push_back('{1'b1, 32'h80000000, 32'h00000000, 32'h80000000, E_NONE, 1'b0});
      for (int i = 0; i <= v.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({fp_out, err_o} !== {e.r, e.e}) begin
               n_fail++;
               $display("FAIL arith[%0d]: fp_out=%h err_o=%0d, expected fp_out=%h err_o=%0d", e.idx, fp_out, err_o, e.r, e.e);
            end
         end
         if (i < v.size()) drive(v[i], i);
      end
   endtask

   task automatic test_rounding();
      vec_t v[$];
      exp_t e;
      v.push_back('{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, E_NONE, 1'b0}); // tie, even stays
      v.push_back('{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, E_NONE, 1'b0}); // tie, odd rounds up
      v.push_back('{1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001, E_NONE, 1'b0}); // above half
      v.push_back('{1'b0, 32'h4B800000, 32'h3F800000, 32'h4B800000, E_NONE, 1'b0}); // 2^24+1 tie
      v.push_back('{1'b0, 32'h3F800000, 32'h2F800000, 32'h3F800000, E_NONE, 1'b0}); // sticky collapse
      v.push_back('{1'b1, 32'h3F800000, 32'h2F800000, 32'h3F800000, E_NONE, 1'b0}); // round carry renorm
      v.push_back('{1'b1, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, E_NONE, 1'b0}); // exact, left shift
      for (int i = 0; i <= v.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({fp_out, err_o} !== {e.r, e.e}) begin
               n_fail++;
               $display("FAIL rounding[%0d]: fp_out=%h err_o=%0d, expected fp_out=%h err_o=%0d", e.idx, fp_out, err_o, e.r, e.e);
            end
         end
         if (i < v.size()) drive(v[i], i);
      end
   endtask

   task automatic test_special();
      vec_t v[$];
      exp_t e;
      v.push_back('{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, E_INV,  1'b0});
      v.push_back('{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, E_INV,  1'b0});
      v.push_back('{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, E_INV,  1'b0});
      v.push_back('{1'b1, 32'h3F800000, 32'hFFC00000, 32'h7FC00000, E_INV,  1'b0});
      v.push_back('{1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, E_NONE, 1'b0});
      v.push_back('{1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, E_NONE, 1'b0});
      v.push_back('{1'b1, 32'h7F800000, 32'hFF800000, 32'h7F800000, E_NONE, 1'b0});
      for (int i = 0; i <= v.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({fp_out, err_o} !== {e.r, e.e}) begin
               n_fail++;
               $display("FAIL special[%0d]: fp_out=%h err_o=%0d, expected fp_out=%h err_o=%0d", e.idx, fp_out, err_o, e.r, e.e);
            end
         end
         if (i < v.size()) drive(v[i], i);
      end
   endtask

   task automatic test_overflow();
      vec_t v[$];
      exp_t e;
      v.push_back('{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, E_OVF, 1'b0});
      v.push_back('{1'b1, 32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFF800000, E_OVF, 1'b0});
      v.push_back('{1'b0, 32'h7F7FFFFF, 32'h73000000, 32'h7F800000, E_OVF, 1'b0}); // rounding carry
      v.push_back('{1'b0, 32'h7F7FFFFF, 32'h72FFFFFF, 32'h7F7FFFFF, E_NONE, 1'b0}); // just below half
      for (int i = 0; i <= v.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({fp_out, err_o} !== {e.r, e.e}) begin
               n_fail++;
               $display("FAIL overflow[%0d]: fp_out=%h err_o=%0d, expected fp_out=%h err_o=%0d", e.idx, fp_out, err_o, e.r, e.e);
            end
         end
         if (i < v.size()) drive(v[i], i);
      end
   endtask

   task automatic test_underflow();
      vec_t v[$];
      exp_t e;
`ifdef FP_SUBNORMAL_EN
      v.push_back('{1'b1, 32'h00800001, 32'h00800000, 32'h00000001, E_NONE, 1'b0});
      v.push_back('{1'b1, 32'h00C00000, 32'h00800000, 32'h00400000, E_NONE, 1'b0});
      v.push_back('{1'b1, 32'h80800000, 32'h80C00000, 32'h00400000, E_NONE, 1'b0});
      v.push_back('{1'b0, 32'h00400000, 32'h00400000, 32'h00800000, E_NONE, 1'b0});
`else
      v.push_back('{1'b1, 32'h00800001, 32'h00800000, 32'h00000000, E_UNF,  1'b0});
      v.push_back('{1'b1, 32'h00C00000, 32'h00800000, 32'h00000000, E_UNF,  1'b0});
      v.push_back('{1'b1, 32'h80800000, 32'h80C00000, 32'h00000000, E_UNF,  1'b0});
      v.push_back('{1'b0, 32'h00400000, 32'h00400000, 32'h00000000, E_NONE, 1'b0});
`endif
      v.push_back('{1'b0, 32'h00400000, 32'h3F800000, 32'h3F800000, E_NONE, 1'b0});
      for (int i = 0; i <= v.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({fp_out, err_o} !== {e.r, e.e}) begin
               n_fail++;
               $display("FAIL underflow[%0d]: fp_out=%h err_o=%0d, expected fp_out=%h err_o=%0d", e.idx, fp_out, err_o, e.r, e.e);
            end
         end
         if (i < v.size()) drive(v[i], i);
      end
   endtask

   // Reset pulse in the middle of a stream; the op sampled with reset high is discarded.
   task automatic test_back_to_back();
      vec_t v[$];
      exp_t e;
      v.push_back('{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, E_NONE, 1'b0});
      v.push_back('{1'b0, 32'h40400000, 32'hBF800000, 32'h40000000, E_NONE, 1'b0});
      v.push_back('{1'b0, 32'h7F800000, 32'hFF800000, 32'h00000000, E_NONE, 1'b1});
      v.push_back('{1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40400000, E_NONE, 1'b0});
      v.push_back('{1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, E_NONE, 1'b0});
      for (int i = 0; i <= v.size(); i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({fp_out, err_o} !== {e.r, e.e}) begin
               n_fail++;
               $display("FAIL back_to_back[%0d]: fp_out=%h err_o=%0d, expected fp_out=%h err_o=%0d", e.idx, fp_out, err_o, e.r, e.e);
            end
         end
         if (i < v.size()) drive(v[i], i);
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_arith();
      test_rounding();
      test_special();
      test_overflow();
      test_underflow();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/add_sub_top_fp32.md
ADD_SUB_TOP_FP32 -- requirements
Module: add_sub_top

Interface
REQ-001 SHALL have parameter EXP_BITS, default 8, exponent field width.
REQ-002 SHALL have parameter SIG_BITS, default 23, stored significand (fraction) width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sign1, input, 1, sign of operand 1.
REQ-006 SHALL have port exp1, input, EXP_BITS, biased exponent of operand 1.
REQ-007 SHALL have port sig1, input, SIG_BITS, fraction of operand 1.
REQ-008 SHALL have ports sign2/exp2/sig2, input, 1/EXP_BITS/SIG_BITS, operand 2 fields.
REQ-009 SHALL have port opcode, input, 1; 0 = ADD (op1+op2), 1 = SUB (op1-op2).
REQ-010 SHALL have port fp_out, output, EXP_BITS+SIG_BITS+1, packed result {sign, exp, frac}, registered.
REQ-011 SHALL have port err_o, output, 3, registered status: 0 NONE, 1 INVALID, 2 OVERFLOW, 3 UNDERFLOW; other codes unused.

Function
REQ-012 SHALL sample operands and opcode on every rising clk edge with reset low and present fp_out/err_o after that edge (latency 1 cycle, throughput 1/cycle, no handshake).
REQ-013 SHALL implement SUB as ADD with sign2 inverted.
REQ-014 SHALL align significands by exponent difference, keeping guard, round, sticky bits; shifts >= SIG_BITS+3 collapse the smaller operand into sticky.
REQ-015 SHALL add magnitudes for equal effective signs, else subtract smaller from larger; result sign = sign of larger-magnitude operand.
REQ-016 SHALL normalise via leading-zero count (left) or 1-bit right shift on carry-out, adjusting exponent.
REQ-017 SHALL round to nearest, ties to even; rounding carry renormalises and increments exponent.
REQ-018 SHALL return +0 for exact cancellation of nonzero operands; (-0)+(-0) = -0; (+0)+(-0) = +0.
REQ-019 SHALL return canonical quiet NaN 0x7FC00000 with err_o=INVALID when either input is NaN or for Inf-Inf (effective).
REQ-020 SHALL return correctly signed Inf, err_o=NONE, when exactly one operand is Inf or both are same-sign Inf.
REQ-021 SHALL return signed Inf with err_o=OVERFLOW when rounded exponent >= 2^EXP_BITS-1 from finite inputs.
REQ-022 SHALL set err_o by priority INVALID > OVERFLOW > UNDERFLOW > NONE.

Reset
REQ-023 SHALL drive fp_out=0 and err_o=NONE on the edge where reset is high.
REQ-024 SHALL discard any operation sampled in a reset cycle; first valid result appears one cycle after reset deasserts with operands applied.

Configuration
REQ-025 SHALL, with macro FP_SUBNORMAL_EN defined, accept subnormal inputs (implicit bit 0, exponent treated as 1) and produce gradual-underflow subnormal results, err_o=UNDERFLOW only when the result is subnormal and inexact, or exactly zero after rounding from nonzero.
REQ-026 SHALL, without FP_SUBNORMAL_EN, treat subnormal inputs as same-signed zero and flush any subnormal result to same-signed zero with err_o=UNDERFLOW.

Verification
REQ-027 SHALL pass: ADD 0x3F800000 + 0x40000000 -> fp_out 0x40400000, err_o NONE, one cycle later.
REQ-028 SHALL pass: SUB 0x3F800000 - 0x3F800000 -> 0x00000000, NONE; ADD 0x3F800000 + 0x33800000 (tie) -> 0x3F800000.
REQ-029 SHALL pass: ADD 0x7F800000 + 0xFF800000 -> 0x7FC00000, INVALID; ADD 0x7FC00001 + 0x3F800000 -> 0x7FC00000, INVALID.
REQ-030 SHALL pass: ADD 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, OVERFLOW; SUB 0xFF7FFFFF - 0x7F7FFFFF -> 0xFF800000, OVERFLOW.
REQ-031 SHALL pass: SUB 0x00800001 - 0x00800000 -> 0x00000001, NONE with FP_SUBNORMAL_EN; -> 0x00000000, UNDERFLOW without.
REQ-032 SHALL pass: reset high for one edge mid-stream of back-to-back ops -> fp_out 0x00000000, err_o NONE; next op resumes 1-cycle latency.
